// File: rtl/dmem_if.sv
// dmem_if: CPU data-memory request/response bundle between the MEM stage
// (initiator, master modport) and the memory model (responder, slave modport).
//   req_valid/req_ready : request handshake, initiator -> responder
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata, req_be   : lane-aligned store data and byte-lane enables
//   rsp_valid/rsp_ready : response handshake, responder -> initiator
//   rsp_rdata, rsp_err  : load data (0 for stores/errors) and error flag
interface dmem_if #(
  parameter int BIT_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [31:0]              req_addr;
  logic [BIT_WIDTH-1:0]     req_wdata;
  logic [BIT_WIDTH/8-1:0]   req_be;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [BIT_WIDTH-1:0]     rsp_rdata;
  logic                     rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the CPU data-memory interface.
// Accepts one load/store at a time, waits LATENCY cycles, performs the access
// on a word-organised RAM with byte-lane write enables, then holds the
// response until the initiator consumes it.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high (storage contents are not reset)
//   bus  : dmem_if slave modport (request/response handshakes)
// Parameters:
//   BIT_WIDTH   : data width, fixed at 32
//   ENTRY_COUNT : number of storage words
//   LATENCY     : cycles from acceptance to rsp_valid, 1..15
module dmem_responder #(
  parameter int BIT_WIDTH   = 32,
  parameter int ENTRY_COUNT = 32,
  parameter int LATENCY     = 2
) (
  input  logic    clk,
  input  logic    rst,
  dmem_if.slave   bus
);

  localparam int BYTES = BIT_WIDTH / 8;
  localparam int IDX_W = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
  localparam logic [29:0] WORD_LIMIT = 30'(ENTRY_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             cnt_reg, cnt_next;
  logic                   accept, access, consume;

  logic                   we_reg;
  logic [31:0]            addr_reg;
  logic [BIT_WIDTH-1:0]   wdata_reg;
  logic [BYTES-1:0]       be_reg;
  logic [BIT_WIDTH-1:0]   rdata_reg;
  logic                   err_reg;

  logic [BIT_WIDTH-1:0]   mem [ENTRY_COUNT];
  logic [IDX_W-1:0]       idx;
  logic                   be_legal;
  logic                   req_err;
  logic                   mem_we;
  logic [BYTES-1:0]       lane_we;

  // Request checks are made on the captured request, so they describe
  // exactly the access that happens at the end of WAIT.
  assign idx = addr_reg[IDX_W+1:2];

  always_comb begin
    be_legal = 1'b0;
    case (be_reg)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  end

  assign req_err = (addr_reg[1:0] != 2'b00)
                 || (addr_reg[31:2] >= WORD_LIMIT)
                 || (we_reg && !be_legal);

  // Next-state and handshake decode.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    access     = 1'b0;
    consume    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = ST_WAIT;
          cnt_next   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          access     = 1'b1;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          consume    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
    end else if (accept) begin
      we_reg    <= bus.req_we;
      addr_reg  <= bus.req_addr;
      wdata_reg <= bus.req_wdata;
      be_reg    <= bus.req_be;
    end
  end

  // Load data is sampled at the access edge, not at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (access) begin
      rdata_reg <= (req_err || we_reg) ? '0 : mem[idx];
      err_reg   <= req_err;
    end else if (consume) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end
  end

  // A reset during WAIT forces state_reg to IDLE, so access (and therefore
  // the write) never fires for a discarded store.
  assign mem_we = access && we_reg && !req_err;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign lane_we[gi] = mem_we && be_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < BYTES; k++) begin
      if (lane_we[k]) begin
        mem[idx][k*8 +: 8] <= wdata_reg[k*8 +: 8];
      end
    end
  end

  assign bus.req_ready = (state_reg == ST_IDLE);
  assign bus.rsp_valid = (state_reg == ST_RESP);
  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_err   = err_reg;

endmodule
